// File: rtl/ddr_test_pkg.sv
// Shared types and constants for the DDR3 read/write self-test stage.
package ddr_test_pkg;

    localparam int ADDR_W = 30;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_DRAIN = 3'd2,
        S_RD    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Byte address just past the test region.
    function automatic logic [ADDR_W-1:0] end_addr(input logic [ADDR_W-1:0] beg,
                                                    input int unsigned words,
                                                    input int unsigned data_width);
        return beg + ADDR_W'(words * (data_width / 8));
    endfunction

endpackage

// File: rtl/ddr_test_checker.sv
// Read-side checker: tags reads through the FIFO latency, compares each word
// against the expected pattern and tracks the error count and first failing index.
module ddr_test_checker
    import ddr_test_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [CNT_W-1:0]      rd_idx
);

    logic [RD_LAT-1:0]     tag;
    logic [DATA_WIDTH-1:0] expected;
    logic                  cmp;

    always_comb begin
        expected = seed + DATA_WIDTH'(rd_idx);
        cmp      = tag[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            rd_idx        <= '0;
        end else begin
            tag[0] <= rd_en;
            for (int unsigned i = 1; i < unsigned'(RD_LAT); i++)
                tag[i] <= tag[i-1];
            if (cmp) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_data != expected) begin
                    if (err_cnt == '0)
                        first_err_idx <= rd_idx;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_rw_tester.sv
// DDR3 self-test traffic stage: writes an incrementing pattern, waits for the
// write path to drain, then reads the region back and checks every word.
module ddr_rw_tester
    import ddr_test_pkg::*;
#(
    parameter int                DATA_WIDTH     = 16,
    parameter int                TEST_WORDS     = 4096,
    parameter logic [ADDR_W-1:0] BEG_ADDR       = 30'd0,
    parameter logic [7:0]        BURST_LEN      = 8'd31,
    parameter int                DRAIN_CYCLES   = 2048,
    parameter int                TIMEOUT_CYCLES = 65535,
    parameter int                RD_LAT         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  calib_done,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_W-1:0]     wr_beg_addr,
    output logic [ADDR_W-1:0]     wr_end_addr,
    output logic [7:0]            wr_burst_len,
    output logic [ADDR_W-1:0]     rd_beg_addr,
    output logic [ADDR_W-1:0]     rd_end_addr,
    output logic [7:0]            rd_burst_len,
    output logic                  rd_mem_enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  busy,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  timeout,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [CNT_W-1:0]      pass_cnt
);

    localparam logic [CNT_W-1:0] WORDS = CNT_W'(TEST_WORDS);

    state_t                state;
    logic [1:0]            calib_meta;
    logic                  calib_sync;
    logic                  wr_q;
    logic [CNT_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      rd_idx;
    logic [31:0]           cnt;
    logic [DATA_WIDTH-1:0] seed;
    logic                  go;
    logic                  run_ok;

    always_comb begin
        wr_beg_addr  = BEG_ADDR;
        rd_beg_addr  = BEG_ADDR;
        wr_end_addr  = end_addr(BEG_ADDR, TEST_WORDS, DATA_WIDTH);
        rd_end_addr  = end_addr(BEG_ADDR, TEST_WORDS, DATA_WIDTH);
        wr_burst_len = BURST_LEN;
        rd_burst_len = BURST_LEN;
        calib_sync   = calib_meta[1];
        go           = start && calib_sync && (state == S_IDLE || state == S_DONE);
        run_ok       = (err_cnt == '0) && !timeout;
        // Requests are gated by rst so the FIFOs see them drop in the reset cycle itself.
        wr_en        = wr_q && !rst;
        rd_en        = (state == S_RD) && rd_valid && (issued < WORDS) && !rst;
    end

    always_ff @(posedge clk) begin
        calib_meta <= {calib_meta[0], calib_done};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_q          <= 1'b0;
            wr_data       <= '0;
            wr_idx        <= '0;
            issued        <= '0;
            cnt           <= '0;
            rd_mem_enable <= 1'b0;
            busy          <= 1'b0;
            test_done     <= 1'b0;
            test_pass     <= 1'b0;
            timeout       <= 1'b0;
            pass_cnt      <= '0;
            seed          <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state     <= S_WR;
                        wr_q      <= 1'b1;
                        wr_data   <= seed;
                        wr_idx    <= '0;
                        issued    <= '0;
                        busy      <= 1'b1;
                        test_done <= 1'b0;
                        test_pass <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                S_WR: begin
                    if (wr_idx == WORDS - 1'b1) begin
                        state <= S_DRAIN;
                        wr_q  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        wr_idx  <= wr_idx + 1'b1;
                        wr_data <= seed + DATA_WIDTH'(wr_idx + 1'b1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == 32'(DRAIN_CYCLES - 1)) begin
                        state         <= S_RD;
                        rd_mem_enable <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RD: begin
                    if (rd_en) begin
                        issued <= issued + 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Completion is seen one cycle after the last compare so err_cnt is final.
                    if (rd_idx == WORDS) begin
                        state         <= S_DONE;
                        rd_mem_enable <= 1'b0;
                        busy          <= 1'b0;
                        test_done     <= 1'b1;
                        test_pass     <= run_ok;
                        if (run_ok) begin
                            pass_cnt <= pass_cnt + 1'b1;
                            seed     <= seed + DATA_WIDTH'(TEST_WORDS);
                        end
                    end else if (!rd_en && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state         <= S_DONE;
                        timeout       <= 1'b1;
                        rd_mem_enable <= 1'b0;
                        busy          <= 1'b0;
                        test_done     <= 1'b1;
                        test_pass     <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ddr_test_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_checker (
        .clk           (clk),
        .rst           (rst),
        .clear         (go),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .seed          (seed),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .rd_idx        (rd_idx)
    );

endmodule

// File: tb/tb_ddr_rw_tester.sv
// Bench for ddr_rw_tester: FIFO/memory loopback model with random read-side
// gaps, optional word corruption and a stalled read path.
module tb_ddr_rw_tester;

    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        rst, start, calib_done;
    logic        wr_en, rd_mem_enable, rd_en, rd_valid;
    logic [15:0] wr_data, rd_data;
    logic [29:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
    logic [7:0]  wr_burst_len, rd_burst_len;
    logic        busy, test_done, test_pass, timeout;
    logic [15:0] err_cnt, first_err_idx, pass_cnt;

    always #5 clk = ~clk;

    ddr_rw_tester #(
        .DATA_WIDTH     (16),
        .TEST_WORDS     (TW),
        .BEG_ADDR       (30'd0),
        .BURST_LEN      (8'd31),
        .DRAIN_CYCLES   (8),
        .TIMEOUT_CYCLES (100),
        .RD_LAT         (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .calib_done    (calib_done),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_beg_addr   (wr_beg_addr),
        .wr_end_addr   (wr_end_addr),
        .wr_burst_len  (wr_burst_len),
        .rd_beg_addr   (rd_beg_addr),
        .rd_end_addr   (rd_end_addr),
        .rd_burst_len  (rd_burst_len),
        .rd_mem_enable (rd_mem_enable),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .test_done     (test_done),
        .test_pass     (test_pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .pass_cnt      (pass_cnt)
    );

    // Loopback model: every written word lands in memory; while reads are
    // enabled words trickle into the read FIFO in order, optionally corrupted.
    logic [15:0] wlog[$];
    logic [15:0] rq[$];
    logic [15:0] cmask = '0;
    bit          stall = 1'b0;
    int unsigned fp = 0;
    int unsigned me_cycles = 0;

    initial begin
        rd_data  = '0;
        rd_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (wr_en) wlog.push_back(wr_data);
        if (rd_en && rq.size() > 0) rd_data <= rq.pop_front();
        if (!rd_mem_enable) begin
            rq.delete();
            fp = 0;
        end else if (!stall && fp < wlog.size() && fp < TW && $urandom_range(3) != 0) begin
            rq.push_back(wlog[fp] ^ (cmask[fp] ? 16'h0001 : 16'h0000));
            fp++;
        end
        rd_valid <= (rq.size() > 0);
        if (rd_mem_enable) me_cycles++;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] cmask;
        bit          stall;
        bit          extra_start;
        bit          exp_pass;
        int unsigned exp_err;
        int unsigned exp_first;
        bit          exp_to;
    } vec_t;

    logic [15:0] exp_seed = '0;
    int unsigned exp_pcnt = 0;

    task automatic run_pass(input vec_t v);
        int unsigned waited;
        int unsigned bad;
        repeat (3) @(negedge clk);
        wlog.delete();
        cmask     = v.cmask;
        stall     = v.stall;
        me_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.extra_start) begin
            repeat (4) @(negedge clk);
            check("busy_in_wr", busy, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (!test_done && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", test_done, 1);
        check("wr_count", wlog.size(), TW);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] != 16'(exp_seed + i)) bad++;
        check("wr_data_bad", bad, 0);
        check("test_pass", test_pass, v.exp_pass);
        check("err_cnt", err_cnt, v.exp_err);
        check("first_err_idx", first_err_idx, v.exp_first);
        check("timeout", timeout, v.exp_to);
        check("rd_mem_en_off", rd_mem_enable, 0);
        check("busy_off", busy, 0);
        if (v.stall) check("timeout_cycles", me_cycles, 100);
        if (v.exp_pass) begin
            exp_seed += 16'(TW);
            exp_pcnt++;
        end
        check("pass_cnt", pass_cnt, exp_pcnt);
        stall = 1'b0;
    endtask

    vec_t tbl[5];

    initial begin
        vec_t v;
        int unsigned waited;
        tbl[0] = '{16'h0000, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[1] = '{16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
        tbl[2] = '{16'h0020, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0};
        tbl[3] = '{16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[4] = '{16'h8001, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0};

        rst = 1'b1; start = 1'b0; calib_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_mem_en", rd_mem_enable, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_flags", {busy, test_done, test_pass, timeout}, 0);
        check("rst_counters", err_cnt | first_err_idx | pass_cnt, 0);
        check("wr_end_addr", wr_end_addr, 32);
        check("rd_end_addr", rd_end_addr, 32);
        check("burst_len", {wr_burst_len, rd_burst_len}, 16'h1F1F);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("nocal_busy", busy, 0);
        check("nocal_writes", wlog.size(), 0);
        calib_done = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_pass(tbl[i]);

        for (int r = 0; r < 4; r++) begin
            v.cmask       = ($urandom_range(1) == 1) ? 16'($urandom & $urandom) : 16'h0000;
            v.stall       = 1'b0;
            v.extra_start = 1'b0;
            v.exp_pass    = (v.cmask == 16'h0000);
            v.exp_err     = $countones(v.cmask);
            v.exp_first   = 0;
            for (int b = TW - 1; b >= 0; b--) if (v.cmask[b]) v.exp_first = b;
            v.exp_to      = 1'b0;
            run_pass(v);
        end

        repeat (3) @(negedge clk);
        wlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (wlog.size() < 7 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("mid_wr_reached", wlog.size(), 7);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_flags", {busy, test_done, test_pass, timeout, rd_mem_enable}, 0);
        check("mid_rst_counters", err_cnt | first_err_idx | pass_cnt, 0);
        rst = 1'b0;
        exp_seed = '0;
        exp_pcnt = 0;
        run_pass(tbl[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
